id_stage_sb: RTL and testbench

Parametrised successor to the combinational decode stage. It decodes one instruction per cycle, reads operands through the external register-file read ports and builds the execute operands, then holds them in an integrated ID/EX output register with valid/ready handshakes. A per-register scoreboard and a flag tracker detect RAW/WAW hazards and unresolved branch conditions internally, replacing the external hazard input. It sits between fetch and execute.

---
 rtl/id_stage_sb.sv | 232 +++++++++++++++++++++++
 tb/tb_id_stage_sb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_sb.sv
// rtl/id_stage_sb.sv - decode stage with ID/EX output register and register/flag scoreboard
// Optional ID_WB_BYPASS_EN: same-cycle writeback data and flag resolution release stalls.
module id_stage_sb #(
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 24,
  parameter int RA_W    = 4,
  parameter int CMD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [RA_W-1:0]   src1,
  output logic [RA_W-1:0]   src2,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic              wb_valid,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flag_valid,
  input  logic              flag_z,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CMD_W-1:0]  exe_cmd,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [RA_W-1:0]   dest,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              is_imm,
  output logic              br_taken,
  output logic              illegal
);

  localparam int NREG = 2 ** RA_W;

  localparam logic [CMD_W-1:0] OP_NOP  = CMD_W'(0);
  localparam logic [CMD_W-1:0] OP_ADD  = CMD_W'(1);
  localparam logic [CMD_W-1:0] OP_SUB  = CMD_W'(2);
  localparam logic [CMD_W-1:0] OP_AND  = CMD_W'(3);
  localparam logic [CMD_W-1:0] OP_OR   = CMD_W'(4);
  localparam logic [CMD_W-1:0] OP_MOVI = CMD_W'(5);
  localparam logic [CMD_W-1:0] OP_MOVR = CMD_W'(6);
  localparam logic [CMD_W-1:0] OP_CMP  = CMD_W'(7);
  localparam logic [CMD_W-1:0] OP_LDR  = CMD_W'(8);
  localparam logic [CMD_W-1:0] OP_STR  = CMD_W'(9);
  localparam logic [CMD_W-1:0] OP_B    = CMD_W'(10);
  localparam logic [CMD_W-1:0] OP_BEQ  = CMD_W'(11);
  localparam logic [CMD_W-1:0] OP_BNE  = CMD_W'(12);

  typedef enum logic [1:0] {V2_ZERO, V2_REG, V2_IMM8, V2_OFF12} v2_sel_e;
  typedef enum logic [1:0] {BR_NONE, BR_ALWAYS, BR_EQ, BR_NE} br_kind_e;

  logic [CMD_W-1:0]  opcode;
  logic [RA_W-1:0]   f_rd, f_rs, f_rt;
  logic [DATA_W-1:0] imm8_sx, off12_sx;

  assign opcode   = instr[INSTR_W-1 -: CMD_W];
  assign f_rd     = instr[8 +: RA_W];
  assign f_rs     = instr[4 +: RA_W];
  assign f_rt     = instr[0 +: RA_W];
  assign imm8_sx  = {{(DATA_W-8){instr[7]}}, instr[7:0]};
  assign off12_sx = {{(DATA_W-12){instr[11]}}, instr[11:0]};

  logic     use1, use2, v1_reg;
  logic     dec_wb, dec_mr, dec_mw, dec_imm, dec_ill, is_cmp, is_bcc;
  v2_sel_e  v2_sel;
  br_kind_e br_kind;

  always_comb begin
    src1    = '0;
    src2    = '0;
    use1    = 1'b0;
    use2    = 1'b0;
    v1_reg  = 1'b0;
    v2_sel  = V2_ZERO;
    br_kind = BR_NONE;
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_imm = 1'b0;
    dec_ill = 1'b0;
    is_cmp  = 1'b0;
    is_bcc  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        src1 = f_rs; src2 = f_rt; use1 = 1'b1; use2 = 1'b1;
        v1_reg = 1'b1; v2_sel = V2_REG; dec_wb = 1'b1;
      end
      OP_MOVI: begin
        v2_sel = V2_IMM8; dec_imm = 1'b1; dec_wb = 1'b1;
      end
      OP_MOVR: begin
        src1 = f_rs; use1 = 1'b1; v1_reg = 1'b1; dec_wb = 1'b1;
      end
      OP_CMP: begin
        src1 = f_rd; src2 = f_rs; use1 = 1'b1; use2 = 1'b1;
        v1_reg = 1'b1; v2_sel = V2_REG; is_cmp = 1'b1;
      end
      OP_LDR: begin
        src1 = f_rs; use1 = 1'b1; v1_reg = 1'b1; dec_wb = 1'b1; dec_mr = 1'b1;
      end
      OP_STR: begin
        src1 = f_rs; src2 = f_rd; use1 = 1'b1; use2 = 1'b1;
        v1_reg = 1'b1; v2_sel = V2_REG; dec_mw = 1'b1;
      end
      OP_B:   begin v2_sel = V2_OFF12; br_kind = BR_ALWAYS; end
      OP_BEQ: begin v2_sel = V2_OFF12; br_kind = BR_EQ; is_bcc = 1'b1; end
      OP_BNE: begin v2_sel = V2_OFF12; br_kind = BR_NE; is_bcc = 1'b1; end
      OP_NOP: ;
      default: dec_ill = 1'b1;
    endcase
  end

  logic              out_valid_q, wb_en_q, mem_r_en_q, mem_w_en_q, is_imm_q, br_taken_q, illegal_q;
  logic [CMD_W-1:0]  exe_cmd_q;
  logic [DATA_W-1:0] val1_q, val2_q;
  logic [RA_W-1:0]   dest_q;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              flag_pending_q, flag_pending_d, flag_z_q;
  logic              byp1, byp2, flag_now;

`ifdef ID_WB_BYPASS_EN
  assign byp1     = wb_valid & (wb_addr == src1) & pending_q[src1];
  assign byp2     = wb_valid & (wb_addr == src2) & pending_q[src2];
  assign flag_now = flag_valid;
`else
  logic unused_wb_data;
  assign byp1           = 1'b0;
  assign byp2           = 1'b0;
  assign flag_now       = 1'b0;
  assign unused_wb_data = ^wb_data;
`endif

  logic [DATA_W-1:0] opnd1, opnd2, val1_c, val2_c;
  logic              flag_use, br_c;

  assign opnd1    = byp1 ? wb_data : reg1;
  assign opnd2    = byp2 ? wb_data : reg2;
  assign flag_use = flag_now ? flag_z : flag_z_q;

  always_comb begin
    val1_c = v1_reg ? opnd1 : '0;
    case (v2_sel)
      V2_REG:   val2_c = opnd2;
      V2_IMM8:  val2_c = imm8_sx;
      V2_OFF12: val2_c = off12_sx;
      default:  val2_c = '0;
    endcase
    case (br_kind)
      BR_ALWAYS: br_c = 1'b1;
      BR_EQ:     br_c = flag_use;
      BR_NE:     br_c = ~flag_use;
      default:   br_c = 1'b0;
    endcase
  end

  logic src_haz, waw_haz, flag_haz, stall, accept, kill;

  assign src_haz  = (use1 & pending_q[src1] & ~byp1) | (use2 & pending_q[src2] & ~byp2);
  assign waw_haz  = dec_wb & pending_q[f_rd];
  assign flag_haz = flag_pending_q & (is_cmp | (is_bcc & ~flag_now));
  assign stall    = src_haz | waw_haz | flag_haz;
  assign in_ready = ~stall & (~out_valid_q | out_ready) & ~rst & ~flush;
  assign accept   = in_valid & in_ready;
  assign kill     = flush & out_valid_q;

  // Clears are applied before sets so a same-cycle set on the same entry wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid) pending_d[wb_addr] = 1'b0;
    if (kill && wb_en_q) pending_d[dest_q] = 1'b0;
    if (accept && dec_wb && (f_rd != '0)) pending_d[f_rd] = 1'b1;
    flag_pending_d = flag_pending_q;
    if (flag_valid || (kill && (exe_cmd_q == OP_CMP))) flag_pending_d = 1'b0;
    if (accept && is_cmp) flag_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      exe_cmd_q      <= '0;
      val1_q         <= '0;
      val2_q         <= '0;
      dest_q         <= '0;
      wb_en_q        <= 1'b0;
      mem_r_en_q     <= 1'b0;
      mem_w_en_q     <= 1'b0;
      is_imm_q       <= 1'b0;
      br_taken_q     <= 1'b0;
      illegal_q      <= 1'b0;
      pending_q      <= '0;
      flag_pending_q <= 1'b0;
      flag_z_q       <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      flag_pending_q <= flag_pending_d;
      if (flag_valid) flag_z_q <= flag_z;
      if (accept) begin
        out_valid_q <= 1'b1;
        exe_cmd_q   <= opcode;
        val1_q      <= val1_c;
        val2_q      <= val2_c;
        dest_q      <= f_rd;
        wb_en_q     <= dec_wb;
        mem_r_en_q  <= dec_mr;
        mem_w_en_q  <= dec_mw;
        is_imm_q    <= dec_imm;
        br_taken_q  <= br_c;
        illegal_q   <= dec_ill;
      end else if (flush || out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign exe_cmd   = exe_cmd_q;
  assign val1      = val1_q;
  assign val2      = val2_q;
  assign dest      = dest_q;
  assign wb_en     = wb_en_q;
  assign mem_r_en  = mem_r_en_q;
  assign mem_w_en  = mem_w_en_q;
  assign is_imm    = is_imm_q;
  assign br_taken  = br_taken_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_id_stage_sb.sv
// tb/tb_id_stage_sb.sv - directed and randomized checks of id_stage_sb against a behavioural model
module tb_id_stage_sb;

`ifdef ID_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst, in_valid, in_ready, wb_valid, flag_valid, flag_z, flush;
  logic        out_valid, out_ready, wb_en, mem_r_en, mem_w_en, is_imm, br_taken, illegal;
  logic [15:0] instr;
  logic [3:0]  src1, src2, wb_addr, dest, exe_cmd;
  logic [23:0] reg1, reg2, wb_data, val1, val2;
  logic [23:0] rf [16];

  assign reg1 = rf[src1];
  assign reg2 = rf[src2];

  id_stage_sb dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .src1(src1), .src2(src2), .reg1(reg1), .reg2(reg2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_valid(flag_valid), .flag_z(flag_z), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .exe_cmd(exe_cmd),
    .val1(val1), .val2(val2), .dest(dest), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .is_imm(is_imm), .br_taken(br_taken), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic seen_ready;

  // Reference state: the op sitting in ID/EX plus which registers/flag are still in flight.
  bit        m_valid, m_wb, m_mr, m_mw, m_imm, m_br, m_ill;
  bit [3:0]  m_cmd, m_dest;
  bit [23:0] m_v1, m_v2;
  bit [15:0] m_pend;
  bit        m_fpend, m_fz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit byp_hit(input bit [3:0] r);
    return BYP && wb_valid && (wb_addr == r) && m_pend[r];
  endfunction

  function automatic bit [23:0] rd_val(input bit [3:0] r);
    return byp_hit(r) ? wb_data : rf[r];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0; m_imm = 0; m_br = 0; m_ill = 0;
    m_cmd = 0; m_dest = 0; m_v1 = 0; m_v2 = 0; m_pend = 0; m_fpend = 0; m_fz = 0;
  endtask

  task automatic step();
    int        op;
    bit [3:0]  rd, rs, rt;
    bit [3:0]  reads[$];
    bit        stall, writes, exp_rdy, acc, fz_now, nbr;
    bit [23:0] nv1, nv2;
    @(negedge clk);
    op = int'(instr[15:12]);
    rd = instr[11:8]; rs = instr[7:4]; rt = instr[3:0];
    case (op)
      1, 2, 3, 4: begin reads.push_back(rs); reads.push_back(rt); end
      6, 8:       reads.push_back(rs);
      7:          begin reads.push_back(rd); reads.push_back(rs); end
      9:          begin reads.push_back(rs); reads.push_back(rd); end
      default: ;
    endcase
    writes = (op >= 1 && op <= 6) || op == 8;
    stall = 0;
    foreach (reads[i]) if (m_pend[reads[i]] && !byp_hit(reads[i])) stall = 1;
    if (writes && m_pend[rd]) stall = 1;
    if (m_fpend && (op == 7 || ((op == 11 || op == 12) && !(BYP && flag_valid)))) stall = 1;
    exp_rdy = !rst && !flush && !stall && (!m_valid || out_ready);
    seen_ready = in_ready;
    chk("in_ready", in_ready, exp_rdy);
    acc = in_valid && exp_rdy;
    fz_now = (BYP && flag_valid) ? flag_z : m_fz;
    nv1 = 0; nv2 = 0; nbr = 0;
    case (op)
      1, 2, 3, 4: begin nv1 = rd_val(rs); nv2 = rd_val(rt); end
      5:          nv2 = {{16{instr[7]}}, instr[7:0]};
      6, 8:       nv1 = rd_val(rs);
      7:          begin nv1 = rd_val(rd); nv2 = rd_val(rs); end
      9:          begin nv1 = rd_val(rs); nv2 = rd_val(rd); end
      10, 11, 12: begin
        nv2 = {{12{instr[11]}}, instr[11:0]};
        nbr = (op == 10) ? 1'b1 : (op == 11) ? fz_now : !fz_now;
      end
      default: ;
    endcase
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (wb_valid) m_pend[wb_addr] = 0;
      if (flush && m_valid && m_wb) m_pend[m_dest] = 0;
      if (flush && m_valid && m_cmd == 7) m_fpend = 0;
      if (flag_valid) begin m_fpend = 0; m_fz = flag_z; end
      if (acc && writes && rd != 0) m_pend[rd] = 1;
      if (acc && op == 7) m_fpend = 1;
      if (acc) begin
        m_valid = 1; m_cmd = instr[15:12]; m_dest = rd; m_v1 = nv1; m_v2 = nv2;
        m_wb = writes; m_mr = (op == 8); m_mw = (op == 9); m_imm = (op == 5);
        m_br = nbr; m_ill = (op >= 13);
      end else if (flush || out_ready) m_valid = 0;
    end
    #1;
    if (wb_valid) rf[wb_addr] = wb_data;
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("exe_cmd", exe_cmd, m_cmd);   chk("val1", val1, m_v1);
      chk("val2", val2, m_v2);          chk("dest", dest, m_dest);
      chk("wb_en", wb_en, m_wb);        chk("mem_r_en", mem_r_en, m_mr);
      chk("mem_w_en", mem_w_en, m_mw);  chk("is_imm", is_imm, m_imm);
      chk("br_taken", br_taken, m_br);  chk("illegal", illegal, m_ill);
    end
  endtask

  task automatic retire(input bit [3:0] r);
    wb_valid = 1; wb_addr = r; wb_data = rf[r];
    step();
    wb_valid = 0;
  endtask

  initial begin
    bit [3:0] pl[$];
    rst = 1; in_valid = 0; instr = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
    flag_valid = 0; flag_z = 0; flush = 0; out_ready = 1;
    for (int i = 0; i < 16; i++) rf[i] = 24'(i * 24'h010101 + 1);
    model_reset();

    // Reset state, then a single ADD.
    step();
    chk("rst_ready", seen_ready, 0); chk("rst_cmd", exe_cmd, 0);
    chk("rst_val1", val1, 0);        chk("rst_val2", val2, 0);
    chk("rst_wb", wb_en, 0);
    rst = 0; rf[2] = 24'd5; rf[3] = 24'd7;
    in_valid = 1; instr = 16'h1123;
    step();
    chk("t1_val1", val1, 24'd5); chk("t1_val2", val2, 24'd7);
    chk("t1_dest", dest, 1);     chk("t1_cmd", exe_cmd, 1);

    // RAW on r1 resolved by writeback.
    instr = 16'h1412;
    step(); chk("t2_stall0", seen_ready, 0);
    step(); chk("t2_stall1", seen_ready, 0);
    wb_valid = 1; wb_addr = 1; wb_data = 24'hABCDEF;
    step(); chk("t2_wbcycle", seen_ready, BYP);
    wb_valid = 0;
    if (!BYP) begin step(); chk("t2_after", seen_ready, 1); end
    in_valid = 0;
    chk("t2_val1", val1, 24'hABCDEF); chk("t2_val2", val2, 24'd5);
    step();
    retire(4);

    // MOVI sign extension and an illegal opcode.
    in_valid = 1; instr = 16'h52FF;
    step();
    chk("t3_val1", val1, 0); chk("t3_val2", val2, 24'hFFFFFF); chk("t3_imm", is_imm, 1);
    instr = 16'hE000;
    step();
    chk("t3_ill", illegal, 1); chk("t3_wb", wb_en, 0); chk("t3_mw", mem_w_en, 0);
    in_valid = 0;
    retire(2);

    // CMP then BEQ waits for the flag.
    in_valid = 1; instr = 16'h7120;
    step();
    instr = 16'hB800;
    step(); chk("t4_stall0", seen_ready, 0);
    step(); chk("t4_stall1", seen_ready, 0);
    flag_valid = 1; flag_z = 1;
    step(); chk("t4_flagcycle", seen_ready, BYP);
    flag_valid = 0; flag_z = 0;
    if (!BYP) step();
    in_valid = 0;
    chk("t4_br", br_taken, 1); chk("t4_val2", val2, 24'hFFF800);
    step();

    // Backpressure holds the ID/EX register.
    in_valid = 1; instr = 16'h1123; out_ready = 0;
    step();
    instr = 16'h5300;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_ready", seen_ready, 0); chk("t5_hold_val1", val1, 24'd5);
      chk("t5_hold_cmd", exe_cmd, 1);
    end
    out_ready = 1;
    step(); chk("t5_accept", seen_ready, 1); chk("t5_cmd", exe_cmd, 5);
    in_valid = 0;
    step();
    retire(1); retire(3);

    // Flush releases the killed op's destination; reset mid-stall.
    in_valid = 1; instr = 16'h1523; out_ready = 0;
    step();
    in_valid = 0; flush = 1;
    step(); chk("t6_flush", out_valid, 0);
    flush = 0; out_ready = 1; in_valid = 1; instr = 16'h6650;
    step(); chk("t6_r5_free", seen_ready, 1);
    instr = 16'h1760;
    step(); chk("t6_stall", seen_ready, 0);
    rst = 1;
    step(); chk("t6_rst_valid", out_valid, 0);
    rst = 0;
    step(); chk("t6_post_rst", seen_ready, 1);
    in_valid = 0;
    step();

    // Randomized traffic.
    rst = 1; step(); rst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom % 150) == 0;
      in_valid  = ($urandom % 4) != 0;
      instr     = 16'($urandom);
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 25) == 0;
      pl.delete();
      for (int r = 0; r < 16; r++) if (m_pend[r]) pl.push_back(4'(r));
      wb_data = 24'($urandom);
      if (pl.size() > 0 && ($urandom % 3) == 0) begin
        wb_valid = 1; wb_addr = pl[$urandom % pl.size()];
      end else begin
        wb_valid = ($urandom % 10) == 0; wb_addr = 4'($urandom);
      end
      flag_valid = m_fpend ? (($urandom % 3) == 0) : (($urandom % 12) == 0);
      flag_z     = 1'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
